// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-op size codes and the data-memory arbiter FSM encoding.
package cpu_pkg;

  localparam logic [1:0] MEMOP_NONE = 2'b00;
  localparam logic [1:0] MEMOP_BYTE = 2'b01;
  localparam logic [1:0] MEMOP_HALF = 2'b10;
  localparam logic [1:0] MEMOP_WORD = 2'b11;

  localparam int ARB_WAIT_W = 4;

  typedef enum logic {
    ARB_S_CPU = 1'b0,
    ARB_S_ACK = 1'b1
  } arb_state_e;

  function automatic logic memop_active(input logic [1:0] re, input logic [1:0] we);
    return (re != MEMOP_NONE) || (we != MEMOP_NONE);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the pipeline MEM stage, the debug/loader master and DataMemory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]        cpu_re;
  logic [1:0]        cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dbg_req;
  logic [1:0]        dbg_re;
  logic [1:0]        dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;

  logic [1:0]        mem_re;
  logic [1:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              owner_dbg;

  // Arbiter side.
  modport slave (
    input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_re, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_re, mem_we, mem_addr, mem_wdata, owner_dbg,
    input  mem_rdata
  );

  // Pipeline / debug master / memory side.
  modport master (
    output cpu_re, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_re, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_re, mem_we, mem_addr, mem_wdata, owner_dbg,
    output mem_rdata
  );
endinterface

// File: rtl/arb_wait_counter.sv
// Saturating starvation counter: clear wins, increments stop at the programmed maximum.
module arb_wait_counter #(
  parameter int W = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  assign at_max = (cnt == max);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single DataMemory port between the CPU MEM stage (priority) and a debug master,
// with a bounded wait before the debug master is forced in for one stall cycle.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  dmem_arbiter_if.slave  bus
);

  localparam logic [ARB_WAIT_W-1:0] WAIT_MAX = ARB_WAIT_W'(MAX_WAIT);

  arb_state_e             state, state_nxt;
  logic                   cpu_req;
  logic                   grant_dbg;
  logic                   in_cpu;
  logic                   wait_clr;
  logic                   wait_inc;
  logic                   at_max;
  logic [ARB_WAIT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0]      dbg_rdata_q;
  logic [1:0]             mem_re_c, mem_we_c;
  logic [ADDR_W-1:0]      mem_addr_c;
  logic [DATA_W-1:0]      mem_wdata_c;

  assign cpu_req = memop_active(bus.cpu_re, bus.cpu_we);
  assign in_cpu  = (state == ARB_S_CPU);

  // Grant is gated by Reset so nothing reaches memory or stalls the pipe while held in reset.
  always_comb begin
    state_nxt = state;
    grant_dbg = 1'b0;
    if (state == ARB_S_CPU) begin
      grant_dbg = Reset & bus.dbg_req & (!cpu_req | at_max);
      if (grant_dbg) state_nxt = ARB_S_ACK;
    end else begin
      state_nxt = ARB_S_CPU;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= ARB_S_CPU;
      dbg_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (grant_dbg) dbg_rdata_q <= bus.mem_rdata;
    end
  end

  assign wait_clr = in_cpu & (grant_dbg | !bus.dbg_req);
  assign wait_inc = in_cpu & bus.dbg_req & cpu_req & !grant_dbg;

  arb_wait_counter #(.W(ARB_WAIT_W)) u_wait (
    .Clk    (Clk),
    .Reset  (Reset),
    .clear  (wait_clr),
    .inc    (wait_inc),
    .max    (WAIT_MAX),
    .cnt    (wait_cnt),
    .at_max (at_max)
  );

  always_comb begin
    mem_re_c    = bus.cpu_re;
    mem_we_c    = bus.cpu_we;
    mem_addr_c  = bus.cpu_addr;
    mem_wdata_c = bus.cpu_wdata;
    if (grant_dbg) begin
      mem_re_c    = bus.dbg_re;
      mem_we_c    = bus.dbg_we;
      mem_addr_c  = bus.dbg_addr;
      mem_wdata_c = bus.dbg_wdata;
    end
    if (!Reset) begin
      mem_re_c = MEMOP_NONE;
      mem_we_c = MEMOP_NONE;
    end
  end

  assign bus.mem_re    = mem_re_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.owner_dbg = grant_dbg;
  assign bus.cpu_stall = grant_dbg & cpu_req;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.dbg_ack   = (state == ARB_S_ACK);
  assign bus.dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, directed corner sequences and a randomized run vs a reference model.
module tb_dmem_arbiter;
  import cpu_pkg::*;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if4 ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if0 ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut4 (.Clk(Clk), .Reset(Reset), .bus(if4.slave));
  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(0)) dut0 (.Clk(Clk), .Reset(Reset), .bus(if0.slave));

  logic [31:0] mem4 [64];
  logic [31:0] mem0 [64];

  assign if4.mem_rdata = mem4[if4.mem_addr[7:2]];
  assign if0.mem_rdata = mem0[if0.mem_addr[7:2]];

  always @(posedge Clk) begin
    if (if4.mem_we != MEMOP_NONE) mem4[if4.mem_addr[7:2]] <= if4.mem_wdata;
    if (if0.mem_we != MEMOP_NONE) mem0[if0.mem_addr[7:2]] <= if0.mem_wdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle4();
    if4.cpu_re = MEMOP_NONE; if4.cpu_we = MEMOP_NONE; if4.cpu_addr = '0; if4.cpu_wdata = '0;
    if4.dbg_req = 1'b0; if4.dbg_re = MEMOP_NONE; if4.dbg_we = MEMOP_NONE;
    if4.dbg_addr = '0; if4.dbg_wdata = '0;
  endtask

  task automatic idle0();
    if0.cpu_re = MEMOP_NONE; if0.cpu_we = MEMOP_NONE; if0.cpu_addr = '0; if0.cpu_wdata = '0;
    if0.dbg_req = 1'b0; if0.dbg_re = MEMOP_NONE; if0.dbg_we = MEMOP_NONE;
    if0.dbg_addr = '0; if0.dbg_wdata = '0;
  endtask

  typedef struct {
    logic       dreq;
    logic [1:0] dre, dwe, cre, cwe;
    logic       eown, estall, eack;
    logic [1:0] emre, emwe;
  } vec_t;

  vec_t tbl [16];

  // Reference model state (MAX_WAIT = 4 instance).
  int          waited;
  bit          ack_pend;
  bit          last_grant;
  bit          grant, creq;
  logic [31:0] exp_rdata;

  initial begin
    idle4(); idle0();
    for (int i = 0; i < 64; i++) begin
      mem4[i] = 32'h1000_0000 + i;
      mem0[i] = 32'h2000_0000 + i;
    end

    // Reset state, with traffic present to show memory controls are forced idle.
    if4.dbg_req = 1'b1; if4.dbg_re = MEMOP_WORD; if4.cpu_re = MEMOP_WORD;
    #2 Reset = 1'b0;
    #1;
    chk("rst_ack",      if4.dbg_ack,   1'b0);
    chk("rst_rdata",    if4.dbg_rdata, 32'h0);
    chk("rst_mem_re",   if4.mem_re,    MEMOP_NONE);
    chk("rst_mem_we",   if4.mem_we,    MEMOP_NONE);
    chk("rst_stall",    if4.cpu_stall, 1'b0);
    chk("rst_owner",    if4.owner_dbg, 1'b0);
    idle4();
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;

    //              dreq dre         dwe         cre         cwe         own  stl  ack  mre         mwe
    tbl[0]  = '{1'b1, MEMOP_WORD, MEMOP_NONE, MEMOP_NONE, MEMOP_NONE, 1'b1,1'b0,1'b0, MEMOP_WORD, MEMOP_NONE};
    tbl[1]  = '{1'b1, MEMOP_WORD, MEMOP_NONE, MEMOP_NONE, MEMOP_NONE, 1'b0,1'b0,1'b1, MEMOP_NONE, MEMOP_NONE};
    tbl[2]  = '{1'b1, MEMOP_WORD, MEMOP_NONE, MEMOP_NONE, MEMOP_NONE, 1'b1,1'b0,1'b0, MEMOP_WORD, MEMOP_NONE};
    tbl[3]  = '{1'b1, MEMOP_WORD, MEMOP_NONE, MEMOP_NONE, MEMOP_NONE, 1'b0,1'b0,1'b1, MEMOP_NONE, MEMOP_NONE};
    tbl[4]  = '{1'b1, MEMOP_WORD, MEMOP_NONE, MEMOP_NONE, MEMOP_NONE, 1'b1,1'b0,1'b0, MEMOP_WORD, MEMOP_NONE};
    tbl[5]  = '{1'b1, MEMOP_WORD, MEMOP_NONE, MEMOP_NONE, MEMOP_NONE, 1'b0,1'b0,1'b1, MEMOP_NONE, MEMOP_NONE};
    tbl[6]  = '{1'b0, MEMOP_NONE, MEMOP_NONE, MEMOP_NONE, MEMOP_NONE, 1'b0,1'b0,1'b0, MEMOP_NONE, MEMOP_NONE};
    tbl[7]  = '{1'b1, MEMOP_BYTE, MEMOP_NONE, MEMOP_WORD, MEMOP_NONE, 1'b0,1'b0,1'b0, MEMOP_WORD, MEMOP_NONE};
    tbl[8]  = '{1'b1, MEMOP_BYTE, MEMOP_NONE, MEMOP_WORD, MEMOP_NONE, 1'b0,1'b0,1'b0, MEMOP_WORD, MEMOP_NONE};
    tbl[9]  = '{1'b1, MEMOP_BYTE, MEMOP_NONE, MEMOP_WORD, MEMOP_NONE, 1'b0,1'b0,1'b0, MEMOP_WORD, MEMOP_NONE};
    tbl[10] = '{1'b1, MEMOP_BYTE, MEMOP_NONE, MEMOP_WORD, MEMOP_NONE, 1'b0,1'b0,1'b0, MEMOP_WORD, MEMOP_NONE};
    tbl[11] = '{1'b1, MEMOP_BYTE, MEMOP_NONE, MEMOP_WORD, MEMOP_NONE, 1'b1,1'b1,1'b0, MEMOP_BYTE, MEMOP_NONE};
    tbl[12] = '{1'b0, MEMOP_NONE, MEMOP_NONE, MEMOP_WORD, MEMOP_NONE, 1'b0,1'b0,1'b1, MEMOP_WORD, MEMOP_NONE};
    tbl[13] = '{1'b1, MEMOP_NONE, MEMOP_NONE, MEMOP_NONE, MEMOP_NONE, 1'b1,1'b0,1'b0, MEMOP_NONE, MEMOP_NONE};
    tbl[14] = '{1'b0, MEMOP_NONE, MEMOP_NONE, MEMOP_NONE, MEMOP_NONE, 1'b0,1'b0,1'b1, MEMOP_NONE, MEMOP_NONE};
    tbl[15] = '{1'b0, MEMOP_NONE, MEMOP_NONE, MEMOP_NONE, MEMOP_HALF, 1'b0,1'b0,1'b0, MEMOP_NONE, MEMOP_HALF};

    for (int i = 0; i < 16; i++) begin
      if4.dbg_req = tbl[i].dreq; if4.dbg_re = tbl[i].dre; if4.dbg_we = tbl[i].dwe;
      if4.cpu_re  = tbl[i].cre;  if4.cpu_we = tbl[i].cwe;
      @(negedge Clk);
      chk($sformatf("vec%0d_owner", i),  if4.owner_dbg, tbl[i].eown);
      chk($sformatf("vec%0d_stall", i),  if4.cpu_stall, tbl[i].estall);
      chk($sformatf("vec%0d_ack", i),    if4.dbg_ack,   tbl[i].eack);
      chk($sformatf("vec%0d_mem_re", i), if4.mem_re,    tbl[i].emre);
      chk($sformatf("vec%0d_mem_we", i), if4.mem_we,    tbl[i].emwe);
      @(posedge Clk); #1;
    end
    idle4();

    // DBG word read with the CPU idle.
    mem4[16] = 32'hDEAD_BEEF;
    if4.dbg_req = 1'b1; if4.dbg_re = MEMOP_WORD; if4.dbg_addr = 32'h40;
    @(negedge Clk);
    chk("rd_owner",    if4.owner_dbg, 1'b1);
    chk("rd_stall",    if4.cpu_stall, 1'b0);
    chk("rd_mem_addr", if4.mem_addr,  32'h40);
    @(posedge Clk); #1;
    idle4();
    @(negedge Clk);
    chk("rd_ack",   if4.dbg_ack,   1'b1);
    chk("rd_rdata", if4.dbg_rdata, 32'hDEAD_BEEF);
    @(posedge Clk); #1;

    // MAX_WAIT=0: DBG write wins against a CPU store to the same word; the store retries next.
    if0.cpu_we = MEMOP_WORD; if0.cpu_addr = 32'h10; if0.cpu_wdata = 32'h11;
    if0.dbg_req = 1'b1; if0.dbg_we = MEMOP_WORD; if0.dbg_addr = 32'h10; if0.dbg_wdata = 32'h22;
    @(negedge Clk);
    chk("col_owner", if0.owner_dbg, 1'b1);
    chk("col_stall", if0.cpu_stall, 1'b1);
    chk("col_wdata", if0.mem_wdata, 32'h22);
    @(posedge Clk); #1;
    chk("col_mem_dbg", mem0[4], 32'h22);
    if0.dbg_req = 1'b0; if0.dbg_we = MEMOP_NONE;
    @(negedge Clk);
    chk("col_owner2", if0.owner_dbg, 1'b0);
    chk("col_ack",    if0.dbg_ack,   1'b1);
    chk("col_wdata2", if0.mem_wdata, 32'h11);
    @(posedge Clk); #1;
    chk("col_mem_cpu", mem0[4], 32'h11);
    idle0();

    // MAX_WAIT=0 with the CPU loading every cycle: granted on the first S_CPU cycle.
    if0.cpu_re = MEMOP_WORD; if0.dbg_req = 1'b1; if0.dbg_re = MEMOP_WORD; if0.dbg_addr = 32'h8;
    @(negedge Clk);
    chk("mw0_owner", if0.owner_dbg, 1'b1);
    chk("mw0_stall", if0.cpu_stall, 1'b1);
    @(posedge Clk); #1;
    if0.dbg_req = 1'b0;
    @(negedge Clk);
    chk("mw0_ack",   if0.dbg_ack,   1'b1);
    chk("mw0_rdata", if0.dbg_rdata, 32'h2000_0002);
    @(posedge Clk); #1;
    idle0();

    // Reset asserted between edges during a DBG write grant.
    if4.dbg_req = 1'b1; if4.dbg_we = MEMOP_WORD; if4.dbg_addr = 32'h20; if4.dbg_wdata = 32'hCAFE_0001;
    if4.cpu_re = MEMOP_WORD;
    repeat (4) begin @(posedge Clk); #1; end
    @(negedge Clk);
    chk("rm_owner_pre", if4.owner_dbg, 1'b1);
    chk("rm_mem_we_pre", if4.mem_we,   MEMOP_WORD);
    #2 Reset = 1'b0;
    #1;
    chk("rm_mem_we", if4.mem_we,    MEMOP_NONE);
    chk("rm_ack",    if4.dbg_ack,   1'b0);
    chk("rm_stall",  if4.cpu_stall, 1'b0);
    @(posedge Clk); #1;
    chk("rm_mem_unwritten", mem4[8], 32'h1000_0008);
    idle4();
    #3 Reset = 1'b1;
    @(negedge Clk);
    chk("rm_ack_after", if4.dbg_ack, 1'b0);
    @(posedge Clk); #1;
    if4.dbg_req = 1'b1; if4.dbg_re = MEMOP_WORD; if4.dbg_addr = 32'h40;
    @(negedge Clk);
    chk("rm_regrant", if4.owner_dbg, 1'b1);
    @(posedge Clk); #1;
    idle4();
    @(negedge Clk);
    chk("rm_ack2",   if4.dbg_ack,   1'b1);
    chk("rm_rdata2", if4.dbg_rdata, 32'hDEAD_BEEF);
    @(posedge Clk); #1;

    // Randomized traffic against the reference model.
    waited = 0; ack_pend = 1'b0; last_grant = 1'b0; exp_rdata = 32'hDEAD_BEEF;
    for (int c = 0; c < 400; c++) begin
      if (!(if4.dbg_req && !last_grant)) begin
        if4.dbg_req   = ($urandom_range(0, 2) == 0);
        if4.dbg_re    = 2'($urandom);
        if4.dbg_we    = (if4.dbg_re == MEMOP_NONE) ? 2'($urandom) : MEMOP_NONE;
        if4.dbg_addr  = {24'h0, 6'($urandom), 2'b00};
        if4.dbg_wdata = $urandom;
      end
      if ($urandom_range(0, 1) == 1) begin
        if4.cpu_re = 2'($urandom);
        if4.cpu_we = (if4.cpu_re == MEMOP_NONE) ? 2'($urandom) : MEMOP_NONE;
      end else begin
        if4.cpu_re = MEMOP_NONE; if4.cpu_we = MEMOP_NONE;
      end
      if4.cpu_addr  = {24'h0, 6'($urandom), 2'b00};
      if4.cpu_wdata = $urandom;
      @(negedge Clk);
      creq  = (if4.cpu_re != MEMOP_NONE) || (if4.cpu_we != MEMOP_NONE);
      grant = !ack_pend && if4.dbg_req && (!creq || waited >= 4);
      chk("rnd_owner",    if4.owner_dbg, grant);
      chk("rnd_stall",    if4.cpu_stall, grant && creq);
      chk("rnd_ack",      if4.dbg_ack,   ack_pend);
      chk("rnd_mem_re",   if4.mem_re,    grant ? if4.dbg_re : if4.cpu_re);
      chk("rnd_mem_we",   if4.mem_we,    grant ? if4.dbg_we : if4.cpu_we);
      chk("rnd_mem_addr", if4.mem_addr,  grant ? if4.dbg_addr : if4.cpu_addr);
      chk("rnd_rdata",    if4.dbg_rdata, exp_rdata);
      if (ack_pend) begin
        ack_pend = 1'b0;
      end else if (grant) begin
        ack_pend  = 1'b1;
        waited    = 0;
        exp_rdata = mem4[if4.dbg_addr[7:2]];
      end else if (!if4.dbg_req) begin
        waited = 0;
      end else if (creq && waited < 4) begin
        waited++;
      end
      last_grant = grant;
      @(posedge Clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single DataMemory port between the pipeline MEM stage (CPU port) and a secondary debug/loader master (DBG port).
- The CPU has priority by default. A saturating wait counter bounds how long DBG can be starved.
- While DBG holds the port, the block raises cpu_stall for one cycle. That cycle freezes the PC and all four pipeline registers, like ID_Stall does.
- Sits in TopLevel between the EX/MEM register outputs and the DataMemory instance.

Parameters:
- ADDR_W, 32, address width of both ports and of the memory.
- DATA_W, 32, data width.
- MAX_WAIT, 4, number of consecutive contended cycles DBG waits before it is forced in (legal range 0..15; 0 means DBG always wins).

Ports:
- Clk  in  1  system clock (the ClkOut domain); all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- cpu_re  in  2  MEM_MemRead size code; 2'b00 = no read.
- cpu_we  in  2  MEM_MemWrite size code; 2'b00 = no write.
- cpu_addr  in  ADDR_W  MEM_ALUResult.
- cpu_wdata  in  DATA_W  MEM_ReadData2.
- cpu_rdata  out  DATA_W  read data to the MEM/WB register.
- cpu_stall  out  1  global pipeline freeze for this cycle.
- dbg_req  in  1  DBG request; held high until dbg_ack.
- dbg_re  in  2  DBG read size code.
- dbg_we  in  2  DBG write size code.
- dbg_addr  in  ADDR_W  DBG address.
- dbg_wdata  in  DATA_W  DBG write data.
- dbg_rdata  out  DATA_W  registered DBG read data.
- dbg_ack  out  1  one-cycle completion pulse.
- mem_re  out  2  to DataMemory MemRead.
- mem_we  out  2  to DataMemory MemWrite.
- mem_addr  out  ADDR_W  to DataMemory.
- mem_wdata  out  DATA_W  to DataMemory.
- mem_rdata  in  DATA_W  from DataMemory (combinational read).
- owner_dbg  out  1  1 when the DBG port drives memory this cycle.

Behaviour:
- Request qualifiers:
  - cpu_req = |cpu_re | |cpu_we.
  - DataMemory reads combinationally and writes on the edge, so every access takes one cycle.
- FSM states:
  - S_CPU: the reset state.
  - S_ACK: DBG was serviced in the previous cycle.
- Grant rule: grant_dbg = (state==S_CPU) & dbg_req & (!cpu_req | wait_cnt==MAX_WAIT).
- Transitions:
  - S_CPU -> S_ACK when grant_dbg.
  - S_ACK -> S_CPU unconditionally.
  - Consequence: DBG is never granted on two consecutive cycles.
- Memory mux:
  - When grant_dbg, the DBG fields drive mem_*.
  - Otherwise the CPU fields drive mem_*, including all-zero codes when the CPU is idle.
  - owner_dbg = grant_dbg.
  - cpu_rdata = mem_rdata always; it is ignored by the pipeline while stalled.
- cpu_stall = grant_dbg & cpu_req. This is combinational, and the CPU access retries on the next cycle unchanged.
- wait_cnt (width 4), updated only in S_CPU:
  - Cleared on grant_dbg or when !dbg_req.
  - Incremented, saturating at MAX_WAIT, when dbg_req & cpu_req & !grant_dbg.
  - Held in S_ACK.
- DBG handshake:
  - dbg_ack = (state==S_ACK), a registered one-cycle pulse.
  - dbg_rdata is loaded from mem_rdata on the grant edge and holds until the next grant.
  - DBG must drop dbg_req or present a new transaction in the ack cycle. A request still high after S_ACK counts as a new access.
- Boundaries:
  - MAX_WAIT=0: DBG is granted on its first S_CPU cycle regardless of the CPU.
  - CPU idle: DBG is granted immediately, with no stall.
  - Both idle: mem_re and mem_we are 2'b00.
  - DBG request with both codes zero: still granted and acked, with no memory side effect.
- Reset (Reset low, asynchronous):
  - state = S_CPU, wait_cnt = 0, dbg_ack = 0, dbg_rdata = 0.
  - mem_we and mem_re are forced to 2'b00 while Reset is low.
  - cpu_stall = 0.
  - A DBG transaction in flight is lost and must be reissued.

Decomposition:
- Shared package (cpu_pkg), contents:
  - MEMOP_NONE = 2'b00 and the existing size codes for MemRead/MemWrite.
  - FSM encodings ARB_S_CPU and ARB_S_ACK.
  - ARB_WAIT_W = 4.
- One sub-module, arb_wait_counter: a saturating counter with clear, inc and max inputs, and an at_max output.

Test Plan:
- DBG read with CPU idle:
  - Stimulus: mem[0x40]=0xDEADBEEF; dbg_req=1, dbg_re=word, dbg_addr=0x40.
  - Response: owner_dbg=1 in cycle 0, cpu_stall=0; dbg_ack=1 in cycle 1; dbg_rdata=0xDEADBEEF.
- Contention with MAX_WAIT=4:
  - Stimulus: CPU issues word loads every cycle; dbg_req is raised at cycle 0.
  - Response: grant and cpu_stall=1 in cycle 4 only; the CPU load at cycle 4 is repeated in cycle 5; ack in cycle 5.
- DBG write during a CPU store:
  - Stimulus: CPU stores 0x11 to 0x10 while DBG writes 0x22 to 0x10 and wins.
  - Response: the DBG write lands first and the CPU store next cycle; final mem[0x10]=0x11.
- Back-to-back DBG:
  - Stimulus: dbg_req held high for 6 cycles with the CPU idle.
  - Response: grants at cycles 0, 2, 4; dbg_ack at cycles 1, 3, 5.
- Reset mid-transaction:
  - Stimulus: Reset asserted low asynchronously in the grant cycle, between edges.
  - Response: mem_we=0, dbg_ack=0 and cpu_stall=0 immediately; state=S_CPU after release.
- MAX_WAIT=0:
  - Stimulus: CPU busy every cycle; dbg_req=1.
  - Response: grant and cpu_stall=1 in cycle 0.
